// File: rtl/hazard_scoreboard.sv
// Forwarding and hazard unit that keeps its own in-flight register-usage
// pipeline: one EX slot plus DEPTH post-EX producer slots. Derives EX operand
// forward selects, MEM store-data forward and the load-use stall.
module hazard_scoreboard #(
  parameter  int unsigned DEPTH   = 3,
  parameter  int unsigned RADDR_W = 4,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned FS_W    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pipe_stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic               id_regwrite,
  input  logic               id_is_load,
  input  logic               id_mem_write,
  output logic [FS_W-1:0]    fwd_a,
  output logic [FS_W-1:0]    fwd_b,
  output logic               fwd_mem,
  output logic               load_use_stall,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef struct packed {
    logic               valid;
    logic [RADDR_W-1:0] rd;
    logic [RADDR_W-1:0] rt;
    logic               regwrite;
    logic               is_load;
    logic               mem_write;
  } slot_t;

  slot_t              r_ex;
  logic [RADDR_W-1:0] r_ex_rs;
  slot_t              r_slot [1:DEPTH];
  logic [CNT_W-1:0]   r_stall_cnt;

  slot_t              w_ex_next;
  logic               w_load_use;
  logic [FS_W-1:0]    w_fwd_a;
  logic [FS_W-1:0]    w_fwd_b;
  logic               w_fwd_mem;

  // A slot produces a register value only if it writes a nonzero register.
  function automatic logic is_writer(slot_t s);
    return s.valid & s.regwrite & (s.rd != '0);
  endfunction

  // Load in EX feeding an ID source that cannot be forwarded in time.
  always_comb begin
    w_load_use = id_valid & is_writer(r_ex) & r_ex.is_load &
                 ((id_uses_rs & (r_ex.rd == id_rs)) |
                  (id_uses_rt & (r_ex.rd == id_rt) & ~id_mem_write));
  end

  // Next EX contents: bubble on flush, load-use stall or empty ID.
  always_comb begin
    w_ex_next = '0;
    if (!(flush | w_load_use | ~id_valid)) begin
      w_ex_next.valid     = 1'b1;
      w_ex_next.rd        = id_rd;
      w_ex_next.rt        = id_rt;
      w_ex_next.regwrite  = id_regwrite;
      w_ex_next.is_load   = id_is_load;
      w_ex_next.mem_write = id_mem_write;
    end
  end

  // Operand forward selects; scanning oldest to youngest lets the youngest
  // match override, and an ineligible youngest match forces 0 (no fallthrough).
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    if (r_ex.valid) begin
      for (int unsigned k = DEPTH; k >= 1; k--) begin
        if (is_writer(r_slot[k]) && (r_slot[k].rd == r_ex_rs))
          w_fwd_a = (k == 1 && r_slot[k].is_load) ? '0 : FS_W'(k);
        if (is_writer(r_slot[k]) && (r_slot[k].rd == r_ex.rt))
          w_fwd_b = (k == 1 && r_slot[k].is_load) ? '0 : FS_W'(k);
      end
    end
  end

  // Store in MEM whose data register is being written back from WB.
  always_comb begin
    w_fwd_mem = r_slot[1].valid & r_slot[1].mem_write & is_writer(r_slot[2]) &
                (r_slot[2].rd == r_slot[1].rt);
  end

  // Slot pipeline advance and saturating stall counter; all hold on pipe_stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex        <= '0;
      r_ex_rs     <= '0;
      r_stall_cnt <= '0;
      for (int unsigned k = 1; k <= DEPTH; k++) r_slot[k] <= '0;
    end else if (!pipe_stall) begin
      for (int unsigned k = DEPTH; k >= 2; k--) r_slot[k] <= r_slot[k-1];
      r_slot[1] <= r_ex;
      r_ex      <= w_ex_next;
      r_ex_rs   <= id_rs;
      if (w_load_use && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign fwd_a          = w_fwd_a;
  assign fwd_b          = w_fwd_b;
  assign fwd_mem        = w_fwd_mem;
  assign load_use_stall = w_load_use;
  assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (DEPTH=3/CNT_W=16 and
// DEPTH=5/CNT_W=4) share stimulus and are checked every cycle against an
// instruction-history model, plus literal expectations on directed sequences.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pipe_stall, flush, id_valid;
  logic [3:0] id_rs, id_rt, id_rd;
  logic       id_uses_rs, id_uses_rt, id_regwrite, id_is_load, id_mem_write;

  logic [1:0]  fa3, fb3;
  logic        fm3, ls3;
  logic [15:0] sc3;
  logic [2:0]  fa5, fb5;
  logic        fm5, ls5;
  logic [3:0]  sc5;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(3), .RADDR_W(4), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .pipe_stall(pipe_stall), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .id_mem_write(id_mem_write),
    .fwd_a(fa3), .fwd_b(fb3), .fwd_mem(fm3), .load_use_stall(ls3), .stall_cnt(sc3)
  );

  hazard_scoreboard #(.DEPTH(5), .RADDR_W(4), .CNT_W(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .pipe_stall(pipe_stall), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .id_mem_write(id_mem_write),
    .fwd_a(fa5), .fwd_b(fb5), .fwd_mem(fm5), .load_use_stall(ls5), .stall_cnt(sc5)
  );

  // ---------------- reference model: instruction history ----------------
  typedef struct packed {
    logic       v;
    logic [3:0] rs, rt, rd;
    logic       rw, ld, mw;
  } ent_t;

  ent_t m_ex;
  ent_t m_slot [1:7];   // m_slot[1] = most recently retired from EX
  int   c16, c4;

  task automatic model_clear();
    m_ex = '0;
    for (int k = 1; k <= 7; k++) m_slot[k] = '0;
    c16 = 0;
    c4  = 0;
  endtask

  function automatic bit m_wr(ent_t e);
    return e.v && e.rw && (e.rd != 4'd0);
  endfunction

  function automatic int mfwd(logic [3:0] src, int depth);
    if (!m_ex.v) return 0;
    for (int k = 1; k <= depth; k++)
      if (m_wr(m_slot[k]) && m_slot[k].rd == src)
        return (k == 1 && m_slot[k].ld) ? 0 : k;
    return 0;
  endfunction

  function automatic int m_fmem();
    return (m_slot[1].v && m_slot[1].mw && m_wr(m_slot[2]) &&
            m_slot[2].rd == m_slot[1].rt) ? 1 : 0;
  endfunction

  function automatic int m_lus();
    if (!id_valid || !m_wr(m_ex) || !m_ex.ld) return 0;
    if (id_uses_rs && m_ex.rd == id_rs) return 1;
    if (id_uses_rt && m_ex.rd == id_rt && !id_mem_write) return 1;
    return 0;
  endfunction

  task automatic model_step();
    int lus;
    if (pipe_stall) return;
    lus = m_lus();
    if (lus != 0) begin
      if (c16 < 65535) c16++;
      if (c4 < 15) c4++;
    end
    for (int k = 7; k >= 2; k--) m_slot[k] = m_slot[k-1];
    m_slot[1] = m_ex;
    if (flush || lus != 0 || !id_valid) m_ex = '0;
    else begin
      m_ex.v  = 1'b1;
      m_ex.rs = id_rs;  m_ex.rt = id_rt;  m_ex.rd = id_rd;
      m_ex.rw = id_regwrite; m_ex.ld = id_is_load; m_ex.mw = id_mem_write;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("fwd_a_d3",  32'(fa3), mfwd(m_ex.rs, 3));
    chk("fwd_b_d3",  32'(fb3), mfwd(m_ex.rt, 3));
    chk("fwd_mem_d3", 32'(fm3), m_fmem());
    chk("stall_d3",  32'(ls3), m_lus());
    chk("cnt_d3",    32'(sc3), c16);
    chk("fwd_a_d5",  32'(fa5), mfwd(m_ex.rs, 5));
    chk("fwd_b_d5",  32'(fb5), mfwd(m_ex.rt, 5));
    chk("fwd_mem_d5", 32'(fm5), m_fmem());
    chk("stall_d5",  32'(ls5), m_lus());
    chk("cnt_d5",    32'(sc5), c4);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                        input logic [3:0] rd, input logic urs, input logic urt,
                        input logic rw, input logic ld, input logic mw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = urs; id_uses_rt = urt;
    id_regwrite = rw; id_is_load = ld; id_mem_write = mw;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_fa3"}, 32'(fa3), 0);
    chk({tag, "_fb3"}, 32'(fb3), 0);
    chk({tag, "_fm3"}, 32'(fm3), 0);
    chk({tag, "_ls3"}, 32'(ls3), 0);
    chk({tag, "_sc3"}, 32'(sc3), 0);
    chk({tag, "_fa5"}, 32'(fa5), 0);
    chk({tag, "_sc5"}, 32'(sc5), 0);
  endtask

  initial begin
    rst_n = 1'b0; pipe_stall = 1'b0; flush = 1'b0;
    idle();
    model_clear();
    #2;
    chk_all_zero("reset");
    #10 rst_n = 1'b1;

    // ALU chain: ADD r3<-r1,r2 ; ADD r4<-r3,r3 ; ADD r5<-r3,r4
    set_id(1, 4'd1, 4'd2, 4'd3, 1, 1, 1, 0, 0); tick();
    set_id(1, 4'd3, 4'd3, 4'd4, 1, 1, 1, 0, 0); tick();
    chk("chain2_fa", 32'(fa3), 1);
    chk("chain2_fb", 32'(fb3), 1);
    set_id(1, 4'd3, 4'd4, 4'd5, 1, 1, 1, 0, 0); tick();
    chk("chain3_fa", 32'(fa3), 2);
    chk("chain3_fb", 32'(fb3), 1);

    // Load-use: LW r2 ; ADD r6<-r2,r1
    set_id(1, 4'd1, 4'd0, 4'd2, 1, 0, 1, 1, 0); tick();
    set_id(1, 4'd2, 4'd1, 4'd6, 1, 1, 1, 0, 0); #1;
    chk("lu_stall", 32'(ls3), 1);
    chk("lu_cnt0", 32'(sc3), 0);
    tick();
    chk("lu_bubble_stall", 32'(ls3), 0);
    chk("lu_cnt1", 32'(sc3), 1);
    tick();
    chk("lu_fwd_a", 32'(fa3), 2);

    // Store after load: LW r2 ; SW r2 -> [r7]
    set_id(1, 4'd1, 4'd0, 4'd2, 1, 0, 1, 1, 0); tick();
    set_id(1, 4'd7, 4'd2, 4'd0, 1, 1, 0, 0, 1); #1;
    chk("st_nostall", 32'(ls3), 0);
    tick();
    chk("st_fwd_b", 32'(fb3), 0);
    idle(); tick();
    chk("st_fwd_mem", 32'(fm3), 1);

    // Write to r0 never forwards
    set_id(1, 4'd1, 4'd1, 4'd0, 1, 1, 1, 0, 0); tick();
    set_id(1, 4'd0, 4'd0, 4'd8, 1, 1, 1, 0, 0); tick();
    chk("r0_fa", 32'(fa3), 0);
    chk("r0_fb", 32'(fb3), 0);

    // Producer visible only in slot 5
    set_id(1, 4'd1, 4'd1, 4'd9, 1, 1, 1, 0, 0); tick();
    idle();
    for (int i = 0; i < 4; i++) tick();
    set_id(1, 4'd9, 4'd1, 4'd10, 1, 1, 1, 0, 0); tick();
    chk("d5_fa", 32'(fa5), 5);
    chk("d3_fa_gone", 32'(fa3), 0);

    // Freeze with flush held, then release with flush
    set_id(1, 4'd11, 4'd12, 4'd13, 1, 1, 1, 0, 0);
    pipe_stall = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    pipe_stall = 1'b0;
    tick();
    flush = 1'b0;
    tick();

    // Twenty load-use stalls
    for (int i = 0; i < 20; i++) begin
      set_id(1, 4'd1, 4'd0, 4'd2, 1, 0, 1, 1, 0); tick();
      set_id(1, 4'd2, 4'd1, 4'd6, 1, 1, 1, 0, 0); tick();
      tick();
    end
    chk("sat_cnt5", 32'(sc5), 15);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      pipe_stall = ($urandom_range(0, 7) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      set_id($urandom_range(0, 4) != 0,
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end

    // Mid-stream asynchronous reset
    pipe_stall = 1'b0; flush = 1'b0;
    set_id(1, 4'd1, 4'd2, 4'd3, 1, 1, 1, 1, 0); tick();
    set_id(1, 4'd3, 4'd3, 4'd4, 1, 1, 1, 0, 0); tick();
    rst_n = 1'b0; #1;
    chk_all_zero("midrst");
    #2 rst_n = 1'b1;
    model_clear();
    idle();
    for (int i = 0; i < 4; i++) tick();
    chk_all_zero("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
